cpu_inta_sequencer: RTL and testbench

CPU_INTA_SEQUENCER -- requirements
Module: cpu_inta_sequencer

---
 rtl/pic_pkg.sv | 15 +
 rtl/sync_2ff.sv | 22 ++
 rtl/cpu_inta_sequencer.sv | 109 ++++++++++
 tb/tb_cpu_inta_sequencer.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pic_pkg.sv
// Shared types for the PIC acknowledge logic: sequencer state encoding and
// the width of the phase-timing down-counter.
package pic_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        INTA1,
        GAP,
        INTA2,
        DELIVER
    } inta_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchronizer for a single asynchronous input; both flops
// clear to 0 on synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cpu_inta_sequencer.sv
// Generates the two-pulse INTA_n handshake to the PIC, captures the vector
// driven during the second pulse and holds it until the core acknowledges it.
module cpu_inta_sequencer
    import pic_pkg::*;
#(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       INT,
    input  logic       IE,
    input  logic [7:0] D_in,
    input  logic       vector_ack,
    output logic       INTA_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LOW_LOAD = CNT_W'(INTA_LOW_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(INTA_GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    inta_state_t      state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             int_s;
    logic             capture;

    sync_2ff u_int_sync (
        .clk   (CLK),
        .rst_n (RST),
        .d     (INT),
        .q     (int_s)
    );

    // Once a sequence starts it always runs to DELIVER; INT_s and IE are only looked at in IDLE.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (int_s && IE) begin
                    next_state = INTA1;
                    cnt_next   = LOW_LOAD;
                end
            end
            INTA1: begin
                if (cnt == CNT_ONE) begin
                    next_state = GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt == CNT_ONE) begin
                    next_state = INTA2;
                    cnt_next   = LOW_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            INTA2: begin
                if (cnt == CNT_ONE) begin
                    next_state = DELIVER;
                    cnt_next   = '0;
                    capture    = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            DELIVER: begin
                if (vector_ack) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // INTA_n is decoded from the next state so the strobe leaves a flop cleanly.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state        <= IDLE;
            cnt          <= '0;
            INTA_n       <= 1'b1;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= cnt_next;
            INTA_n <= !((next_state == INTA1) || (next_state == INTA2));
            if (capture) begin
                vector       <= D_in;
                vector_valid <= 1'b1;
            end else if (state == DELIVER && vector_ack) begin
                vector_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_cpu_inta_sequencer.sv
// Drives two sequencer instances (default timing and 1/15 timing) with shared
// stimulus and checks them against a timeline model of the acknowledge cycle.
module tb_cpu_inta_sequencer;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       INT = 1'b0;
    logic       IE = 1'b0;
    logic       vector_ack = 1'b0;
    logic [7:0] D_in = 8'h00;

    logic       inta_n0, vv0, busy0;
    logic [7:0] vec0;
    logic       inta_n1, vv1, busy1;
    logic [7:0] vec1;

    int n_vec = 0;
    int n_mis = 0;

    always #5 CLK = ~CLK;

    cpu_inta_sequencer #(.INTA_LOW_CYCLES(2), .INTA_GAP_CYCLES(2)) u_dut0 (
        .CLK(CLK), .RST(RST), .INT(INT), .IE(IE), .D_in(D_in),
        .vector_ack(vector_ack), .INTA_n(inta_n0), .vector(vec0),
        .vector_valid(vv0), .busy(busy0)
    );

    cpu_inta_sequencer #(.INTA_LOW_CYCLES(1), .INTA_GAP_CYCLES(15)) u_dut1 (
        .CLK(CLK), .RST(RST), .INT(INT), .IE(IE), .D_in(D_in),
        .vector_ack(vector_ack), .INTA_n(inta_n1), .vector(vec1),
        .vector_valid(vv1), .busy(busy1)
    );

    // Model: mode 0 = waiting, 1 = acknowledge in progress (t = edges since start), 2 = holding vector.
    int         lows[2] = '{2, 1};
    int         gaps[2] = '{2, 15};
    int         m_mode[2];
    int         m_t[2];
    logic       m_s1[2];
    logic       m_s2[2];
    logic [7:0] m_vec[2];
    logic       m_vv[2];

    task automatic model_step();
        logic seen;
        for (int i = 0; i < 2; i++) begin
            if (!RST) begin
                m_mode[i] = 0;
                m_t[i]    = 0;
                m_s1[i]   = 1'b0;
                m_s2[i]   = 1'b0;
                m_vec[i]  = 8'h00;
                m_vv[i]   = 1'b0;
            end else begin
                seen    = m_s2[i];
                m_s2[i] = m_s1[i];
                m_s1[i] = INT;
                case (m_mode[i])
                    0: if (seen && IE) begin
                        m_mode[i] = 1;
                        m_t[i]    = 0;
                    end
                    1: begin
                        m_t[i] = m_t[i] + 1;
                        if (m_t[i] == 2 * lows[i] + gaps[i]) begin
                            m_mode[i] = 2;
                            m_vec[i]  = D_in;
                            m_vv[i]   = 1'b1;
                        end
                    end
                    default: if (vector_ack) begin
                        m_mode[i] = 0;
                        m_vv[i]   = 1'b0;
                    end
                endcase
            end
        end
    endtask

    function automatic logic model_inta_n(int i);
        return !(m_mode[i] == 1 &&
                 (m_t[i] < lows[i] || m_t[i] >= lows[i] + gaps[i]));
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] act,
                               input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        checkOutput("dut0 INTA_n", {7'b0, inta_n0}, {7'b0, model_inta_n(0)});
        checkOutput("dut0 vector", vec0, m_vec[0]);
        checkOutput("dut0 vector_valid", {7'b0, vv0}, {7'b0, m_vv[0]});
        checkOutput("dut0 busy", {7'b0, busy0}, {7'b0, m_mode[0] != 0});
        checkOutput("dut1 INTA_n", {7'b0, inta_n1}, {7'b0, model_inta_n(1)});
        checkOutput("dut1 vector", vec1, m_vec[1]);
        checkOutput("dut1 vector_valid", {7'b0, vv1}, {7'b0, m_vv[1]});
        checkOutput("dut1 busy", {7'b0, busy1}, {7'b0, m_mode[1] != 0});
    endtask

    task automatic applyStimulus(input logic rst, input logic irq, input logic ie,
                                 input logic [7:0] din, input logic ack);
        RST        = rst;
        INT        = irq;
        IE         = ie;
        D_in       = din;
        vector_ack = ack;
    endtask

    // One rising edge: advance the model, then compare 1 time unit later.
    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
    endtask

    initial begin
        // Basic sequence on both instances, then the hold/ack behaviour.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle();
        cycle();
        checkOutput("reset INTA_n", {7'b0, inta_n0}, 8'h01);
        checkOutput("reset busy", {7'b0, busy0}, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h4A, 1'b0);
        for (int e = 1; e <= 30; e++) begin
            cycle();
            if (e == 2) checkOutput("lit e2 busy", {7'b0, busy0}, 8'h00);
            if (e == 3) checkOutput("lit e3 INTA_n", {7'b0, inta_n0}, 8'h00);
            if (e == 5) checkOutput("lit e5 INTA_n", {7'b0, inta_n0}, 8'h01);
            if (e == 7) checkOutput("lit e7 INTA_n", {7'b0, inta_n0}, 8'h00);
            if (e == 8) checkOutput("lit e8 vector_valid", {7'b0, vv0}, 8'h00);
            if (e == 9) begin
                checkOutput("lit e9 INTA_n", {7'b0, inta_n0}, 8'h01);
                checkOutput("lit e9 vector", vec0, 8'h4A);
                checkOutput("lit e9 vector_valid", {7'b0, vv0}, 8'h01);
                checkOutput("lit e9 busy", {7'b0, busy0}, 8'h01);
            end
            if (e == 3) checkOutput("lit slow e3 INTA_n", {7'b0, inta_n1}, 8'h00);
            if (e == 4) checkOutput("lit slow e4 INTA_n", {7'b0, inta_n1}, 8'h01);
            if (e == 18) checkOutput("lit slow e18 INTA_n", {7'b0, inta_n1}, 8'h01);
            if (e == 19) checkOutput("lit slow e19 INTA_n", {7'b0, inta_n1}, 8'h00);
            if (e == 19) checkOutput("lit slow e19 valid", {7'b0, vv1}, 8'h00);
            if (e == 20) checkOutput("lit slow e20 vector", vec1, 8'h4A);
            if (e == 20) checkOutput("lit slow e20 valid", {7'b0, vv1}, 8'h01);
            if (e == 30) checkOutput("lit e30 held valid", {7'b0, vv0}, 8'h01);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 1'b1);
        cycle();
        checkOutput("lit ack valid", {7'b0, vv0}, 8'h00);
        checkOutput("lit ack busy", {7'b0, busy0}, 8'h00);
        checkOutput("lit ack vector kept", vec0, 8'h4A);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        for (int e = 0; e < 30; e++) cycle();

        // Reset on the edge that would enter the second pulse.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h33, 1'b0);
        for (int e = 1; e <= 6; e++) cycle();
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
        cycle();
        checkOutput("lit rst INTA_n", {7'b0, inta_n0}, 8'h01);
        checkOutput("lit rst vector", vec0, 8'h00);
        checkOutput("lit rst valid", {7'b0, vv0}, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h33, 1'b0);
        for (int e = 1; e <= 3; e++) begin
            cycle();
            if (e == 2) checkOutput("lit restart e2 INTA_n", {7'b0, inta_n0}, 8'h01);
            if (e == 3) checkOutput("lit restart e3 INTA_n", {7'b0, inta_n0}, 8'h00);
        end

        // IE held off, then enabled: strobe one edge later.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        for (int e = 0; e < 20; e++) cycle();
        checkOutput("lit IE off busy", {7'b0, busy0}, 8'h00);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
        cycle();
        checkOutput("lit IE on INTA_n", {7'b0, inta_n0}, 8'h00);

        // INT withdrawn during the gap: the sequence still completes.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h00, 1'b0);
        for (int e = 1; e <= 9; e++) begin
            cycle();
            if (e == 5) applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 1'b0);
            if (e == 7) checkOutput("lit spurious INTA2", {7'b0, inta_n0}, 8'h00);
        end
        checkOutput("lit spurious vector", vec0, 8'hFF);
        checkOutput("lit spurious valid", {7'b0, vv0}, 8'h01);

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 4000; k++) begin
            applyStimulus(($urandom_range(0, 199) != 0),
                          ($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)),
                          8'($urandom),
                          ($urandom_range(0, 7) == 0));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
